// File: rtl/wb_subproj_arbiter.sv
// Wishbone classic arbiter: routes mgmt SoC accesses in 0x30xx_xxxx to up to four
// sub-project slaves and a small internal register block, with an ack timeout.
module wb_subproj_arbiter #(
    parameter int NSLV    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [NSLV-1:0]     s_cyc_o,
    output logic [NSLV-1:0]     s_stb_o,
    output logic                s_we_o,
    output logic [3:0]          s_sel_o,
    output logic [19:0]         s_adr_o,
    output logic [31:0]         s_dat_o,
    input  logic [NSLV-1:0]     s_ack_i,
    input  logic [32*NSLV-1:0]  s_dat_i,
    output logic [1:0]          io_sel_o,
    output logic                err_irq_o
);

    localparam logic [3:0]  EN_MASK  = 4'((5'd1 << NSLV) - 5'd1);
    localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
    localparam logic [31:0] ID_VALUE = 32'h5355_4231;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_r, state_nxt;
    logic [1:0]      slv_r, slv_nxt;
    logic [NSLV-1:0] cyc_r, cyc_nxt;
    logic            we_r, we_nxt;
    logic [3:0]      sel_r, sel_nxt;
    logic [19:0]     adr_r, adr_nxt;
    logic [31:0]     sdat_r, sdat_nxt;
    logic [7:0]      wait_r, wait_nxt;
    logic            ack_r, ack_nxt;
    logic [31:0]     dato_r, dato_nxt;
    logic            err_r, err_nxt;
    logic [1:0]      io_sel_r, io_sel_nxt;
    logic [3:0]      en_r, en_nxt;
    logic [7:0]      tocnt_r, tocnt_nxt;
    logic [3:0]      eslot_r, eslot_nxt;

    logic            req_s, win_s, slv_hit_s, int_hit_s, ack_sel_s;
    logic [3:0]      slot_s, onehot_s, ack_pad_s;
    logic [31:0]     int_rdat_s, slv_rdat_s;

    // Address decode, internal register read mux and selected-slave response
    always_comb begin
        req_s     = wbs_cyc_i & wbs_stb_i;
        slot_s    = wbs_adr_i[23:20];
        win_s     = (wbs_adr_i[31:24] == 8'h30);
        slv_hit_s = win_s && (int'(slot_s) < NSLV) && en_r[slot_s[1:0]];
        int_hit_s = win_s && (slot_s == 4'hF);
        onehot_s  = 4'b0001 << slot_s[1:0];
        ack_pad_s = 4'(s_ack_i);
        ack_sel_s = ack_pad_s[slv_r];
        slv_rdat_s = s_dat_i[{slv_r, 5'd0} +: 32];
        case (wbs_adr_i[3:2])
            2'd0:    int_rdat_s = {24'd0, en_r, 2'b00, io_sel_r};
            2'd1:    int_rdat_s = {20'd0, eslot_r, tocnt_r};
            2'd2:    int_rdat_s = ID_VALUE;
            default: int_rdat_s = 32'd0;
        endcase
    end

    // Next-state, response and register-file update logic
    always_comb begin
        state_nxt  = state_r;
        slv_nxt    = slv_r;
        cyc_nxt    = cyc_r;
        we_nxt     = we_r;
        sel_nxt    = sel_r;
        adr_nxt    = adr_r;
        sdat_nxt   = sdat_r;
        wait_nxt   = wait_r;
        ack_nxt    = 1'b0;
        dato_nxt   = 32'd0;
        err_nxt    = 1'b0;
        io_sel_nxt = io_sel_r;
        en_nxt     = en_r;
        tocnt_nxt  = tocnt_r;
        eslot_nxt  = eslot_r;
        case (state_r)
            IDLE: begin
                wait_nxt = 8'd0;
                if (req_s && slv_hit_s) begin
                    state_nxt = REQ;
                    slv_nxt   = slot_s[1:0];
                    cyc_nxt   = onehot_s[NSLV-1:0];
                    we_nxt    = wbs_we_i;
                    sel_nxt   = wbs_sel_i;
                    adr_nxt   = wbs_adr_i[19:0];
                    sdat_nxt  = wbs_dat_i;
                end else if (req_s && int_hit_s) begin
                    state_nxt = RESP;
                    ack_nxt   = 1'b1;
                    if (wbs_we_i) begin
                        case (wbs_adr_i[3:2])
                            2'd0: begin
                                if (wbs_sel_i[0]) begin
                                    io_sel_nxt = wbs_dat_i[1:0];
                                    en_nxt     = wbs_dat_i[7:4] & EN_MASK;
                                end else begin
                                    io_sel_nxt = io_sel_r;
                                end
                            end
                            2'd1:    tocnt_nxt = 8'd0;
                            default: tocnt_nxt = tocnt_r;
                        endcase
                    end else begin
                        dato_nxt = int_rdat_s;
                    end
                end else if (req_s) begin
                    state_nxt = RESP;
                    ack_nxt   = 1'b1;
                    err_nxt   = 1'b1;
                    eslot_nxt = slot_s;
                    dato_nxt  = wbs_we_i ? 32'd0 : ERR_DATA;
                end else begin
                    state_nxt = IDLE;
                end
            end
            REQ: begin
                // A master abandoning the cycle takes precedence over any slave ack
                if (!wbs_cyc_i) begin
                    state_nxt = IDLE;
                    cyc_nxt   = '0;
                end else if (ack_sel_s) begin
                    state_nxt = RESP;
                    cyc_nxt   = '0;
                    ack_nxt   = 1'b1;
                    dato_nxt  = we_r ? 32'd0 : slv_rdat_s;
                end else if (wait_r == TO_LAST) begin
                    state_nxt = RESP;
                    cyc_nxt   = '0;
                    ack_nxt   = 1'b1;
                    err_nxt   = 1'b1;
                    eslot_nxt = {2'b00, slv_r};
                    tocnt_nxt = (tocnt_r == 8'hFF) ? tocnt_r : tocnt_r + 8'd1;
                    dato_nxt  = we_r ? 32'd0 : ERR_DATA;
                end else begin
                    wait_nxt = wait_r + 8'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cyc_nxt   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r  <= IDLE;
            slv_r    <= 2'd0;
            cyc_r    <= '0;
            we_r     <= 1'b0;
            sel_r    <= 4'd0;
            adr_r    <= 20'd0;
            sdat_r   <= 32'd0;
            wait_r   <= 8'd0;
            ack_r    <= 1'b0;
            dato_r   <= 32'd0;
            err_r    <= 1'b0;
            io_sel_r <= 2'd0;
            en_r     <= 4'hF & EN_MASK;
            tocnt_r  <= 8'd0;
            eslot_r  <= 4'd0;
        end else begin
            state_r  <= state_nxt;
            slv_r    <= slv_nxt;
            cyc_r    <= cyc_nxt;
            we_r     <= we_nxt;
            sel_r    <= sel_nxt;
            adr_r    <= adr_nxt;
            sdat_r   <= sdat_nxt;
            wait_r   <= wait_nxt;
            ack_r    <= ack_nxt;
            dato_r   <= dato_nxt;
            err_r    <= err_nxt;
            io_sel_r <= io_sel_nxt;
            en_r     <= en_nxt;
            tocnt_r  <= tocnt_nxt;
            eslot_r  <= eslot_nxt;
        end
    end

    assign wbs_ack_o = ack_r;
    assign wbs_dat_o = dato_r;
    assign s_cyc_o   = cyc_r;
    assign s_stb_o   = cyc_r;
    assign s_we_o    = we_r;
    assign s_sel_o   = sel_r;
    assign s_adr_o   = adr_r;
    assign s_dat_o   = sdat_r;
    assign io_sel_o  = io_sel_r;
    assign err_irq_o = err_r;

endmodule

// File: tb/tb_wb_subproj_arbiter.sv
// Scoreboard bench for wb_subproj_arbiter: stimulus queues expected responses,
// a negedge monitor pops and compares them on every wbs_ack_o.
module tb_wb_subproj_arbiter;

    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i;
    logic         wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]   wbs_sel_i;
    logic [31:0]  wbs_adr_i, wbs_dat_i;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic [3:0]   s_cyc_o, s_stb_o;
    logic         s_we_o;
    logic [3:0]   s_sel_o;
    logic [19:0]  s_adr_o;
    logic [31:0]  s_dat_o;
    logic [3:0]   s_ack_i;
    logic [127:0] s_dat_i;
    logic [1:0]   io_sel_o;
    logic         err_irq_o;

    wb_subproj_arbiter #(.NSLV(4), .TIMEOUT(255)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .io_sel_o(io_sel_o), .err_irq_o(err_irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: every ack must match the oldest queued expectation
    always @(negedge wb_clk_i) begin
        if (mon_en) begin
            if (wbs_ack_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_ack: got ack with data %h, expected no ack", wbs_dat_o);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check({e.name, "_data"}, wbs_dat_o, e.dat);
                    check({e.name, "_err"}, {31'd0, err_irq_o}, {31'd0, e.err});
                end
            end else begin
                if (err_irq_o !== 1'b0) begin
                    tests++;
                    fails++;
                    $display("FAIL err_outside_resp: got %b expected 0", err_irq_o);
                end
                if (wbs_dat_o !== 32'd0) begin
                    tests++;
                    fails++;
                    $display("FAIL dat_outside_resp: got %h expected 0", wbs_dat_o);
                end
            end
        end
    end

    // One Wishbone transfer; also plays the addressed slave, acking ack_lat cycles after strobe
    task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                        input logic [3:0] sel, input int ack_lat, input logic [3:0] noise,
                        output int lat, output logic [3:0] stb_seen, output logic [19:0] adr_seen,
                        output logic [31:0] dat_seen, output logic we_seen);
        int k;
        bit done;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
        s_ack_i = noise;
        lat = 0; k = 0; done = 1'b0;
        stb_seen = 4'd0; adr_seen = 20'd0; dat_seen = 32'd0; we_seen = 1'b0;
        while (!done && lat < 400) begin
            @(negedge wb_clk_i);
            lat++;
            if (wbs_ack_o === 1'b1) begin
                done = 1'b1;
            end else begin
                if (s_stb_o != 4'd0) begin
                    stb_seen |= s_stb_o;
                    adr_seen = s_adr_o;
                    dat_seen = s_dat_o;
                    we_seen  = s_we_o;
                    k++;
                end
                s_ack_i = noise;
                if (ack_lat >= 0 && s_stb_o != 4'd0 && k == ack_lat + 1)
                    s_ack_i = noise | s_stb_o;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; s_ack_i = 4'd0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL xfer_no_ack: adr %h got no ack within 400 cycles, expected ack", adr);
        end
    endtask

    // Queue the expected response, run the transfer, check latency and strobe pattern
    task automatic txn(input string name, input logic [31:0] adr, input logic [31:0] dat,
                       input logic we, input logic [3:0] sel, input int ack_lat,
                       input logic [3:0] noise, input logic [31:0] exp_dat, input logic exp_err,
                       input int exp_lat, input logic [3:0] exp_stb);
        int          lat;
        logic [3:0]  stb;
        logic [19:0] a;
        logic [31:0] d;
        logic        w;
        exp_t        e;
        e.dat = exp_dat; e.err = exp_err; e.name = name;
        sb_q.push_back(e);
        xfer(adr, dat, we, sel, ack_lat, noise, lat, stb, a, d, w);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_stb"}, {28'd0, stb}, {28'd0, exp_stb});
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [3:0]  stb;
        logic [19:0] a;
        logic [31:0] d;
        logic        w;
        exp_t        e;

        wb_rst_i = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'd0; wbs_adr_i = 32'd0; wbs_dat_i = 32'd0;
        s_ack_i = 4'd0;
        s_dat_i = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("rst_stb", {28'd0, s_stb_o}, 32'd0);
        check("rst_cyc", {28'd0, s_cyc_o}, 32'd0);
        check("rst_io_sel", {30'd0, io_sel_o}, 32'd0);
        wb_rst_i = 1'b0;
        mon_en = 1'b1;

        txn("id_read",   32'h30F0_0008, 32'd0, 1'b0, 4'hF, -1, 4'd0, 32'h5355_4231, 1'b0, 1, 4'd0);
        txn("ctrl_read", 32'h30F0_0000, 32'd0, 1'b0, 4'hF, -1, 4'd0, 32'h0000_00F0, 1'b0, 1, 4'd0);

        // Write to slave 2 acked 3 cycles after strobe: ack appears 5 cycles after sampling
        e.dat = 32'd0; e.err = 1'b0; e.name = "slv2_write";
        sb_q.push_back(e);
        xfer(32'h3020_0010, 32'h0000_1234, 1'b1, 4'hF, 3, 4'd0, lat, stb, a, d, w);
        check("slv2_write_lat", 32'(lat), 32'd5);
        check("slv2_write_stb", {28'd0, stb}, 32'h0000_0004);
        check("slv2_write_adr", {12'd0, a}, 32'h0000_0010);
        check("slv2_write_dat", d, 32'h0000_1234);
        check("slv2_write_we", {31'd0, w}, 32'd1);

        txn("slv3_read", 32'h3030_0004, 32'd0, 1'b0, 4'hF, 0, 4'd0, 32'hA5A5_0003, 1'b0, 2, 4'b1000);
        // Acks from non-selected slaves must be ignored
        txn("slv0_noise", 32'h3000_0000, 32'd0, 1'b0, 4'hF, 2, 4'b1110, 32'hA5A5_0000, 1'b0, 4, 4'b0001);

        txn("unmap_win",   32'h4000_0000, 32'd0,         1'b0, 4'hF, -1, 4'd0, 32'hDEAD_BEEF, 1'b1, 1, 4'd0);
        txn("unmap_slot4", 32'h3040_0000, 32'd0,         1'b0, 4'hF, -1, 4'd0, 32'hDEAD_BEEF, 1'b1, 1, 4'd0);
        txn("unmap_write", 32'h3050_0000, 32'h1111_2222, 1'b1, 4'hF, -1, 4'd0, 32'd0,         1'b1, 1, 4'd0);

        // Timeout at TIMEOUT=255: strobe held 255 cycles, ack on the 256th
        txn("slv1_timeout", 32'h3010_0000, 32'd0, 1'b0, 4'hF, -1, 4'd0, 32'hDEAD_BEEF, 1'b1, 256, 4'b0010);
        txn("status_1",     32'h30F0_0004, 32'd0, 1'b0, 4'hF, -1, 4'd0, 32'h0000_0101, 1'b0, 1, 4'd0);
        // Ack in the same cycle the counter hits TIMEOUT-1 completes normally
        txn("slv0_race",    32'h3000_0000, 32'd0, 1'b0, 4'hF, 254, 4'd0, 32'hA5A5_0000, 1'b0, 256, 4'b0001);
        txn("status_race",  32'h30F0_0004, 32'd0, 1'b0, 4'hF, -1, 4'd0, 32'h0000_0101, 1'b0, 1, 4'd0);
        txn("status_clr",   32'h30F0_0004, 32'h0000_00AA, 1'b1, 4'hF, -1, 4'd0, 32'd0, 1'b0, 1, 4'd0);
        txn("status_0",     32'h30F0_0004, 32'd0, 1'b0, 4'hF, -1, 4'd0, 32'h0000_0100, 1'b0, 1, 4'd0);

        for (int i = 0; i < 260; i++)
            txn("slv2_to_loop", 32'h3020_0000, 32'd0, 1'b0, 4'hF, -1, 4'd0, 32'hDEAD_BEEF, 1'b1, 256, 4'b0100);
        txn("status_sat", 32'h30F0_0004, 32'd0, 1'b0, 4'hF, -1, 4'd0, 32'h0000_02FF, 1'b0, 1, 4'd0);

        // CTRL=0x23 through byte lane 0: IO_SEL=3, EN=4'b0010 so only slave 1 stays enabled
        txn("ctrl_write", 32'h30F0_0000, 32'h0000_0023, 1'b1, 4'b0001, -1, 4'd0, 32'd0, 1'b0, 1, 4'd0);
        check("io_sel_3", {30'd0, io_sel_o}, 32'd3);
        txn("ctrl_nolane", 32'h30F0_0000, 32'hFFFF_FF00, 1'b1, 4'b1110, -1, 4'd0, 32'd0, 1'b0, 1, 4'd0);
        txn("ctrl_rd23",   32'h30F0_0000, 32'd0, 1'b0, 4'hF, -1, 4'd0, 32'h0000_0023, 1'b0, 1, 4'd0);
        txn("dis_slv0",    32'h3000_0000, 32'd0, 1'b0, 4'hF, -1, 4'd0, 32'hDEAD_BEEF, 1'b1, 1, 4'd0);
        txn("dis_slv2",    32'h3020_0000, 32'd0, 1'b0, 4'hF, -1, 4'd0, 32'hDEAD_BEEF, 1'b1, 1, 4'd0);
        txn("en_slv1",     32'h3010_0000, 32'd0, 1'b0, 4'hF, 1, 4'd0, 32'hA5A5_0001, 1'b0, 3, 4'b0010);
        txn("reg3_write",  32'h30F0_000C, 32'hFFFF_FFFF, 1'b1, 4'hF, -1, 4'd0, 32'd0, 1'b0, 1, 4'd0);
        txn("reg3_read",   32'h30F0_000C, 32'd0, 1'b0, 4'hF, -1, 4'd0, 32'd0, 1'b0, 1, 4'd0);
        txn("ctrl_en_all", 32'h30F0_0000, 32'h0000_00F1, 1'b1, 4'b0001, -1, 4'd0, 32'd0, 1'b0, 1, 4'd0);

        // Master drops cyc while slave 3 is strobed: no ack, no error, TOCNT untouched
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3030_0000;
        @(negedge wb_clk_i);
        check("abort_stb_on", {28'd0, s_stb_o}, 32'h0000_0008);
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge wb_clk_i);
        check("abort_stb_off", {28'd0, s_stb_o}, 32'd0);
        repeat (5) @(negedge wb_clk_i);
        txn("status_abort", 32'h30F0_0004, 32'd0, 1'b0, 4'hF, -1, 4'd0, 32'h0000_02FF, 1'b0, 1, 4'd0);

        // Reset while a write to slave 0 is in REQ
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3000_0ABC; wbs_dat_i = 32'h0000_CAFE;
        @(negedge wb_clk_i);
        check("mid_stb", {28'd0, s_stb_o}, 32'h0000_0001);
        check("mid_adr", {12'd0, s_adr_o}, 32'h0000_0ABC);
        wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(negedge wb_clk_i);
        check("rst_mid_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("rst_mid_err", {31'd0, err_irq_o}, 32'd0);
        check("rst_mid_stb", {28'd0, s_stb_o}, 32'd0);
        check("rst_mid_cyc", {28'd0, s_cyc_o}, 32'd0);
        check("rst_mid_we",  {31'd0, s_we_o}, 32'd0);
        check("rst_mid_sel", {28'd0, s_sel_o}, 32'd0);
        check("rst_mid_adr", {12'd0, s_adr_o}, 32'd0);
        check("rst_mid_sdat", s_dat_o, 32'd0);
        check("rst_mid_dato", wbs_dat_o, 32'd0);
        check("rst_mid_io_sel", {30'd0, io_sel_o}, 32'd0);
        wb_rst_i = 1'b0;
        txn("ctrl_after_rst",   32'h30F0_0000, 32'd0, 1'b0, 4'hF, -1, 4'd0, 32'h0000_00F0, 1'b0, 1, 4'd0);
        txn("status_after_rst", 32'h30F0_0004, 32'd0, 1'b0, 4'hF, -1, 4'd0, 32'h0000_0000, 1'b0, 1, 4'd0);

        repeat (3) @(negedge wb_clk_i);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
